// File: rtl/sd_bidir_pio_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_bidir_pio_if
// Purpose : Avalon-MM slave bundle for the bidirectional PIO (bus + irq)
// Revision: 1.0 - initial release
// ============================================================================
interface sd_bidir_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );
endinterface
`default_nettype wire

// File: rtl/sd_bidir_pio.sv
`default_nettype none
// ============================================================================
// Module  : sd_bidir_pio
// Purpose : WIDTH-pin bidirectional PIO with edge capture and level irq
// Revision: 1.0 - initial release
// ============================================================================
module sd_bidir_pio #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    sd_bidir_pio_if.slave         bus,
    inout  wire       [WIDTH-1:0] bidir_port
);

    localparam logic [2:0] c_ADDR_DATA    = 3'd0;
    localparam logic [2:0] c_ADDR_DIR     = 3'd1;
    localparam logic [2:0] c_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0]                  r_data_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_irq_mask;
    logic [WIDTH-1:0]                  r_edge_cap;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev_in;
    logic [31:0]                       r_readdata;

    logic                              w_wr;
    logic [WIDTH-1:0]                  w_wd;
    logic [WIDTH-1:0]                  w_sync_in;
    logic [WIDTH-1:0]                  w_det;
    logic [WIDTH-1:0]                  w_cap_clr;
    logic [WIDTH-1:0]                  w_data_out_next;
    logic [31:0]                       w_rd_next;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_wd      = bus.writedata[WIDTH-1:0];
    assign w_sync_in = r_sync[SYNC_STAGES-1];

    if (WIDTH < 32) begin : g_unused_wd
        logic w_unused;
        assign w_unused = ^bus.writedata[31:WIDTH];
    end

    // Each pin is driven only while its direction bit selects output
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = r_dir[i] ? r_data_out[i] : 1'bz;
    end

    // Input synchroniser: the pad value enters at index 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '0;
            r_prev_in <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bidir_port};
            r_prev_in <= w_sync_in;
        end
    end

    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign w_det = w_sync_in & ~r_prev_in;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign w_det = ~w_sync_in & r_prev_in;
    end else begin : g_edge_any
        assign w_det = w_sync_in ^ r_prev_in;
    end

    assign w_cap_clr = (w_wr && bus.address == c_ADDR_EDGECAP) ? w_wd : '0;

    always_comb begin
        w_data_out_next = r_data_out;
        if (w_wr) begin
            case (bus.address)
                c_ADDR_DATA:   w_data_out_next = w_wd;
                c_ADDR_OUTSET: w_data_out_next = r_data_out | w_wd;
                c_ADDR_OUTCLR: w_data_out_next = r_data_out & ~w_wd;
                default:       w_data_out_next = r_data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_OUT;
            r_dir      <= RESET_DIR;
            r_irq_mask <= '0;
        end else begin
            r_data_out <= w_data_out_next;
            if (w_wr && bus.address == c_ADDR_DIR) begin
                r_dir <= w_wd;
            end
            if (w_wr && bus.address == c_ADDR_IRQMASK) begin
                r_irq_mask <= w_wd;
            end
        end
    end

    // A new detection overrides a same-cycle software clear so no edge is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_det;
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (bus.address)
            c_ADDR_DATA:    w_rd_next[WIDTH-1:0] = w_sync_in;
            c_ADDR_DIR:     w_rd_next[WIDTH-1:0] = r_dir;
            c_ADDR_IRQMASK: w_rd_next[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGECAP: w_rd_next[WIDTH-1:0] = r_edge_cap;
            default:        w_rd_next            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_next;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_sd_bidir_pio.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_bidir_pio
// Purpose : Two PIO instances (any-edge and rising-edge) against a cycle model
// Revision: 1.0 - initial release
// ============================================================================
module tb_sd_bidir_pio;
    localparam int W = 8;
    localparam int S = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sd_bidir_pio_if bus_a ();
    sd_bidir_pio_if bus_b ();

    assign bus_b.address    = bus_a.address;
    assign bus_b.chipselect = bus_a.chipselect;
    assign bus_b.write_n    = bus_a.write_n;
    assign bus_b.writedata  = bus_a.writedata;

    wire  [W-1:0] pin_a;
    wire  [W-1:0] pin_b;
    logic [W-1:0] ext_val = '0;
    wire  [W-1:0] ext_en;

    sd_bidir_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .bidir_port(pin_a));
    sd_bidir_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b), .bidir_port(pin_b));

    // The bench plays the external card: it drives every pin the PIO is not driving
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign pin_a[i] = ext_en[i] ? ext_val[i] : 1'bz;
        assign pin_b[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = any-edge instance, 1 = rising-edge instance
    logic [W-1:0]  m_out = '0, m_dir = '0, m_mask = '0;
    logic [W-1:0]  n_out = '0, n_dir = '0, n_mask = '0;
    logic [W-1:0]  m_cap [2] = '{default: '0};
    logic [W-1:0]  n_cap [2] = '{default: '0};
    logic [31:0]   m_rd  [2] = '{default: '0};
    logic [31:0]   n_rd  [2] = '{default: '0};
    logic [W-1:0]  pend = '0;
    logic [W-1:0]  hist [$];
    logic [W-1:0]  t_sy, t_pv, t_rise, t_fall, t_wd, t_clr;
    logic          t_wr;

    assign ext_en = ~m_dir;

    // Pin value as seen k samples before the newest one; 0 before reset history
    function automatic logic [W-1:0] hget(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            check("readdata_any",  bus_a.readdata, m_rd[0]);
            check("readdata_rise", bus_b.readdata, m_rd[1]);
            check("irq_any",  {31'd0, bus_a.irq}, {31'd0, |(m_cap[0] & m_mask)});
            check("irq_rise", {31'd0, bus_b.irq}, {31'd0, |(m_cap[1] & m_mask)});
            check("pins_any",  {24'd0, pin_a}, {24'd0, (m_dir & m_out) | (~m_dir & ext_val)});
            check("pins_rise", {24'd0, pin_b}, {24'd0, (m_dir & m_out) | (~m_dir & ext_val)});

            t_sy   = hget(S - 1);
            t_pv   = hget(S);
            t_rise = t_sy & ~t_pv;
            t_fall = ~t_sy & t_pv;
            t_wr   = bus_a.chipselect && !bus_a.write_n;
            t_wd   = bus_a.writedata[W-1:0];
            n_out  = m_out;
            n_dir  = m_dir;
            n_mask = m_mask;
            if (t_wr) begin
                case (bus_a.address)
                    3'd0: n_out  = t_wd;
                    3'd1: n_dir  = t_wd;
                    3'd2: n_mask = t_wd;
                    3'd4: n_out  = m_out | t_wd;
                    3'd5: n_out  = m_out & ~t_wd;
                    default: ;
                endcase
            end
            t_clr    = (t_wr && bus_a.address == 3'd3) ? t_wd : '0;
            n_cap[0] = (m_cap[0] & ~t_clr) | t_rise | t_fall;
            n_cap[1] = (m_cap[1] & ~t_clr) | t_rise;
            for (int c = 0; c < 2; c++) begin
                case (bus_a.address)
                    3'd0:    n_rd[c] = 32'(t_sy);
                    3'd1:    n_rd[c] = 32'(m_dir);
                    3'd2:    n_rd[c] = 32'(m_mask);
                    3'd3:    n_rd[c] = 32'(m_cap[c]);
                    default: n_rd[c] = 32'd0;
                endcase
            end
            pend = pin_a;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out    <= '0;
            m_dir    <= '0;
            m_mask   <= '0;
            m_cap[0] <= '0;
            m_cap[1] <= '0;
            m_rd[0]  <= '0;
            m_rd[1]  <= '0;
            hist.delete();
        end else begin
            m_out    <= n_out;
            m_dir    <= n_dir;
            m_mask   <= n_mask;
            m_cap[0] <= n_cap[0];
            m_cap[1] <= n_cap[1];
            m_rd[0]  <= n_rd[0];
            m_rd[1]  <= n_rd[1];
            hist.push_back(pend);
            if (hist.size() > S + 2) void'(hist.pop_front());
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_a.address    = a;
        bus_a.writedata  = d;
        bus_a.chipselect = 1'b1;
        bus_a.write_n    = 1'b0;
        cyc(1);
        bus_a.chipselect = 1'b0;
        bus_a.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] da, output logic [31:0] db);
        bus_a.address    = a;
        bus_a.chipselect = 1'b1;
        bus_a.write_n    = 1'b1;
        cyc(1);
        da = bus_a.readdata;
        db = bus_b.readdata;
        bus_a.chipselect = 1'b0;
    endtask

    logic [31:0] da, db;

    initial begin
        bus_a.address    = 3'd0;
        bus_a.chipselect = 1'b0;
        bus_a.write_n    = 1'b1;
        bus_a.writedata  = 32'd0;
        cyc(3);
        check("reset_readdata", bus_a.readdata, 32'd0);
        check("reset_irq", {31'd0, bus_a.irq}, 32'd0);
        check("reset_pins_tristate", {24'd0, pin_a}, 32'd0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), da, db);
            check("post_reset_read_any", da, 32'd0);
            check("post_reset_read_rise", db, 32'd0);
        end

        // Output path: direction, load, atomic set and clear
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'hA5);
        check("pins_after_data", {28'd0, pin_a[3:0]}, 32'h5);
        wr(3'd4, 32'h02);
        check("pins_after_outset", {28'd0, pin_a[3:0]}, 32'h7);
        wr(3'd5, 32'h04);
        check("pins_after_outclr", {28'd0, pin_a[3:0]}, 32'h3);
        cyc(S + 2);
        rd(3'd0, da, db);
        check("data_readback", da, 32'h03);

        // Edge capture on pin 6 and interrupt masking
        cyc(4);
        wr(3'd3, 32'hFF);
        cyc(2);
        ext_val[6] = 1'b1;
        cyc(S + 3);
        rd(3'd3, da, db);
        check("edgecap_pin6_any", da, 32'h40);
        check("edgecap_pin6_rise", db, 32'h40);
        check("irq_masked", {31'd0, bus_a.irq}, 32'd0);
        wr(3'd2, 32'h40);
        check("irq_unmasked", {31'd0, bus_a.irq}, 32'd1);
        ext_val[6] = 1'b0;
        cyc(S + 3);
        wr(3'd3, 32'h40);
        check("irq_after_clear", {31'd0, bus_a.irq}, 32'd0);

        // Clear lands on the same edge as a new detection: the set must win
        ext_val[6] = 1'b1;
        cyc(S + 3);
        ext_val[6] = 1'b0;
        cyc(S);
        wr(3'd3, 32'h40);
        check("set_beats_clear_irq", {31'd0, bus_a.irq}, 32'd1);
        rd(3'd3, da, db);
        check("set_beats_clear_any", da, 32'h40);
        check("clear_rise_only", db, 32'h00);

        // Rising-only instance on pin 1
        wr(3'd1, 32'h00);
        ext_val[1] = 1'b1;
        cyc(S + 3);
        wr(3'd3, 32'hFF);
        cyc(2);
        ext_val[1] = 1'b0;
        cyc(S + 3);
        rd(3'd3, db, db);
        rd(3'd3, da, db);
        check("rise_ignores_fall", db, 32'h00);
        ext_val[1] = 1'b1;
        cyc(S + 3);
        rd(3'd3, da, db);
        check("rise_captures", db, 32'h02);
        ext_val[1] = 1'b0;
        cyc(S + 3);
        wr(3'd3, 32'hFF);
        cyc(1);
        ext_val[1] = 1'b1;
        cyc(1);
        ext_val[1] = 1'b0;
        cyc(S + 3);
        rd(3'd3, da, db);
        check("short_pulse_rise", db, 32'h02);
        check("short_pulse_any", da, 32'h02);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    bus_a.chipselect = 1'b1;
                    bus_a.write_n    = 1'b0;
                end
                1: begin
                    bus_a.chipselect = 1'b1;
                    bus_a.write_n    = 1'b1;
                end
                2: begin
                    bus_a.chipselect = 1'b0;
                    bus_a.write_n    = 1'b0;
                end
                default: begin
                    bus_a.chipselect = 1'b0;
                    bus_a.write_n    = 1'b1;
                end
            endcase
            bus_a.address   = 3'($urandom_range(0, 7));
            bus_a.writedata = $urandom;
            if ($urandom_range(0, 2) == 0) ext_val[$urandom_range(0, W - 1)] ^= 1'b1;
            cyc(1);
        end
        bus_a.chipselect = 1'b0;
        bus_a.write_n    = 1'b1;

        // Asynchronous reset while every pin is driven
        ext_val = '0;
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h5A);
        cyc(S + 3);
        check("pins_all_driven", {24'd0, pin_a}, 32'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_pins_any", {24'd0, pin_a}, 32'h00);
        check("async_reset_pins_rise", {24'd0, pin_b}, 32'h00);
        check("async_reset_readdata", bus_a.readdata, 32'd0);
        check("async_reset_irq", {31'd0, bus_a.irq | bus_b.irq}, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), da, db);
            check("reread_after_reset_any", da, 32'd0);
            check("reread_after_reset_rise", db, 32'd0);
        end
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
